rob_alloc_ctrl: RTL and testbench
=================================

ROB_ALLOC_CTRL -- requirements
Module: rob_alloc_ctrl

Interface
REQ-001 Parameter ROB_DEPTH, default 16: ROB entry count, power of two.
REQ-002 Parameter IDX_W, default 4: ROB index width, log2(ROB_DEPTH).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 disp_req_a  input  1  dispatch slot A (older) requests a ROB entry.
REQ-006 disp_req_b  input  1  dispatch slot B (younger) requests a ROB entry.
REQ-007 retire_a  input  1  oldest entry (head) retired this cycle.
REQ-008 retire_b  input  1  second-oldest entry (head+1) retired this cycle.
REQ-009 flush  input  1  discard all in-flight entries.
REQ-010 grant_a  output  1  slot A allocated this cycle.
REQ-011 grant_b  output  1  slot B allocated this cycle.
REQ-012 rob_num_a  output  IDX_W  entry index for slot A, equal to tail.
REQ-013 rob_num_b  output  IDX_W  entry index for slot B, tail+1 mod ROB_DEPTH.
REQ-014 stall  output  1  at least one dispatch request was not granted.
REQ-015 head_ptr  output  IDX_W  oldest valid entry index.
REQ-016 count  output  IDX_W+1  number of occupied entries, 0..ROB_DEPTH.
REQ-017 full, empty  output  1 each  count==ROB_DEPTH, count==0.
REQ-018 err  output  1  sticky protocol-error flag.

Function
REQ-019 State: head, tail (IDX_W bits each), count (IDX_W+1 bits), FSM {RUN, RECOVER}.
REQ-020 free = ROB_DEPTH - registered count; same-cycle retires do not raise free (conservative).
REQ-021 grant_a = disp_req_a & (free>=1) & state==RUN & !flush, combinational from registered state.
REQ-022 grant_b = disp_req_b & disp_req_a & (free>=2) & state==RUN & !flush; slot B never granted ahead of slot A.
REQ-023 stall = (disp_req_a & !grant_a) | (disp_req_b & !grant_b).
REQ-024 Next tail = tail + grant_a + grant_b mod ROB_DEPTH; wraps 15->0 with no bubble.
REQ-025 Next head = head + retire_a + (retire_a & retire_b) mod ROB_DEPTH.
REQ-026 Next count = count + grants - retires; simultaneous dispatch and retire on a full ROB yields count unchanged and stall=1 in that cycle.
REQ-027 retire_b without retire_a, or retires exceeding count, sets err, is ignored (head, count unchanged for the illegal part), err held until reset.
REQ-028 disp_req_b without disp_req_a sets err; no grant issued.
REQ-029 flush (any state): next head=tail=0, count=0, state=RECOVER; grants 0 and retires ignored in the flush cycle.
REQ-030 RECOVER lasts exactly one cycle, grants forced 0, stall=1 if requested; then RUN.
REQ-031 flush asserted while in RECOVER restarts the one-cycle RECOVER.
REQ-032 full, empty, count, head_ptr reflect registered state only.

Reset
REQ-033 On reset: head=tail=0, count=0, state=RUN, err=0; hence grant_a=grant_b=0 unless requested, rob_num_a=0, rob_num_b=1, empty=1, full=0, stall=0 with no requests.
REQ-034 reset dominates flush and all other inputs in the same cycle.

Structure
REQ-035 ROB_DEPTH, ROB_IDX_W and the FSM state enum robAllocState_e live in package typedefs; robNum fields in robDispatchStruct and completeStruct use ROB_IDX_W.
REQ-036 Single flat module; no sub-module required; pointer increment is modular IDX_W-bit addition.
REQ-037 rob_num_a/rob_num_b drive robDispatch_a.robNum/robDispatch_b.robNum; retire_a/retire_b are driven by retire_instr_a.valid/retire_instr_b.valid.

Verification
REQ-038 Reset, then req_a=req_b=1 for 8 cycles, no retires -> grants 1/1 each cycle, rob_num pairs 0/1..14/15, full=1 after cycle 8, then stall=1, grants 0.
REQ-039 count=15 (tail=15), req_a=req_b=1 -> grant_a=1 rob_num_a=15, grant_b=0, stall=1; next cycle count=16 full=1.
REQ-040 head=14, count=4, retire_a=retire_b=1 -> head=0, count=2; then retire_a only -> head=1, count=1.
REQ-041 full ROB, retire_a=1 and req_a=1 same cycle -> grant_a=0, stall=1, count=15; next cycle grant_a=1, rob_num_a=tail.
REQ-042 count=7, flush=1 with req_a=1 -> grant_a=0; next cycle count=0, head=tail=0, RECOVER, grant_a=0, stall=1; following cycle grant_a=1, rob_num_a=0.
REQ-043 empty ROB, retire_a=1 -> err=1, count stays 0; err stays 1 until reset.

Source files
------------

// File: rtl/rob_alloc_ctrl_pkg.sv
// Shared ROB sizing, allocator state encoding and dispatch/complete record layouts.
// Both record layouts carry a ROB index sized by ROB_IDX_W.
package rob_alloc_ctrl_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);

  typedef enum logic [0:0] {
    ROB_RUN     = 1'b0,
    ROB_RECOVER = 1'b1
  } robAllocState_e;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] robNum;
  } robDispatchStruct;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] robNum;
  } completeStruct;

endpackage

// File: rtl/rob_alloc_ctrl.sv
// Dual-slot ROB entry allocator. It tracks the head, tail and occupancy of a
// circular reorder buffer and runs a one-cycle recovery state after each flush.
module rob_alloc_ctrl
  import rob_alloc_ctrl_pkg::*;
#(
  parameter int ROB_DEPTH = rob_alloc_ctrl_pkg::ROB_DEPTH,
  parameter int IDX_W     = rob_alloc_ctrl_pkg::ROB_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             disp_req_a,
  input  logic             disp_req_b,
  input  logic             retire_a,
  input  logic             retire_b,
  input  logic             flush,
  output logic             grant_a,
  output logic             grant_b,
  output logic [IDX_W-1:0] rob_num_a,
  output logic [IDX_W-1:0] rob_num_b,
  output logic             stall,
  output logic [IDX_W-1:0] head_ptr,
  output logic [IDX_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(ROB_DEPTH);

  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [IDX_W:0]   r_count;
  robAllocState_e   r_state;
  logic             r_err;

  logic [IDX_W:0]   w_free;
  logic             w_run;
  logic             w_grant_a;
  logic             w_grant_b;
  logic [1:0]       w_n_grant;
  logic [1:0]       w_ret_req;
  logic             w_ret_over;
  logic [1:0]       w_ret_eff;
  logic             w_err_set;

  // Free space is taken from the registered count only: a retire in this
  // cycle never frees room for a dispatch in the same cycle.
  always_comb begin
    w_free    = DEPTH_C - r_count;
    w_run     = (r_state == ROB_RUN);
    w_grant_a = disp_req_a & (w_free >= (IDX_W+1)'(1)) & w_run & ~flush;
    w_grant_b = disp_req_b & disp_req_a & (w_free >= (IDX_W+1)'(2)) & w_run & ~flush;
    w_n_grant = {1'b0, w_grant_a} + {1'b0, w_grant_b};
  end

  // A lone retire_b retires nothing. Retiring past the occupancy retires
  // only what is there. Both cases raise err.
  always_comb begin
    w_ret_req  = retire_a ? (retire_b ? 2'd2 : 2'd1) : 2'd0;
    w_ret_over = (IDX_W+1)'(w_ret_req) > r_count;
    w_ret_eff  = w_ret_over ? r_count[1:0] : w_ret_req;
    w_err_set  = (disp_req_b & ~disp_req_a)
               | (~flush & ((retire_b & ~retire_a) | w_ret_over));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_state <= ROB_RUN;
      r_err   <= 1'b0;
    end else begin
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_state <= ROB_RECOVER;
      end else begin
        r_head  <= r_head + IDX_W'(w_ret_eff);
        r_tail  <= r_tail + IDX_W'(w_n_grant);
        r_count <= r_count + (IDX_W+1)'(w_n_grant) - (IDX_W+1)'(w_ret_eff);
        r_state <= ROB_RUN;
      end
    end
  end

  assign grant_a   = w_grant_a;
  assign grant_b   = w_grant_b;
  assign rob_num_a = r_tail;
  assign rob_num_b = r_tail + IDX_W'(1);
  assign stall     = (disp_req_a & ~w_grant_a) | (disp_req_b & ~w_grant_b);
  assign head_ptr  = r_head;
  assign count     = r_count;
  assign full      = (r_count == DEPTH_C);
  assign empty     = (r_count == '0);
  assign err       = r_err;

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Bench for rob_alloc_ctrl: an occupancy model built from integers is compared on every
// cycle, literal checks cover the directed scenarios, and random traffic follows.
module tb_rob_alloc_ctrl;

  localparam int D  = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, disp_req_a, disp_req_b, retire_a, retire_b, flush;
  logic          grant_a, grant_b, stall, full, empty, err;
  logic [IW-1:0] rob_num_a, rob_num_b, head_ptr;
  logic [IW:0]   count;

  rob_alloc_ctrl #(.ROB_DEPTH(D), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset),
    .disp_req_a(disp_req_a), .disp_req_b(disp_req_b),
    .retire_a(retire_a), .retire_b(retire_b), .flush(flush),
    .grant_a(grant_a), .grant_b(grant_b),
    .rob_num_a(rob_num_a), .rob_num_b(rob_num_b),
    .stall(stall), .head_ptr(head_ptr), .count(count),
    .full(full), .empty(empty), .err(err)
  );

  // The reference model: entry pointers and occupancy held as plain integers.
  int m_head = 0, m_tail = 0, m_count = 0;
  bit m_rec = 0, m_err = 0;
  int n_tests = 0, n_fail = 0;

  function automatic int exp_ga();
    return (disp_req_a && (D - m_count) >= 1 && !m_rec && !flush) ? 1 : 0;
  endfunction

  function automatic int exp_gb();
    return (disp_req_b && disp_req_a && (D - m_count) >= 2 && !m_rec && !flush) ? 1 : 0;
  endfunction

  always @(posedge clk) begin : model
    int ga, gb, want;
    ga = exp_ga();
    gb = exp_gb();
    if (reset) begin
      m_head <= 0; m_tail <= 0; m_count <= 0; m_rec <= 0; m_err <= 0;
    end else begin
      if (disp_req_b && !disp_req_a) m_err <= 1;
      if (flush) begin
        m_head <= 0; m_tail <= 0; m_count <= 0; m_rec <= 1;
      end else begin
        want = retire_a ? (retire_b ? 2 : 1) : 0;
        if (retire_b && !retire_a) m_err <= 1;
        if (want > m_count) begin
          m_err <= 1;
          want = m_count;
        end
        m_head  <= (m_head + want) % D;
        m_tail  <= (m_tail + ga + gb) % D;
        m_count <= m_count + ga + gb - want;
        m_rec   <= 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int ga, gb, a_stall;
    ga = exp_ga();
    gb = exp_gb();
    a_stall = ((disp_req_a && !ga) || (disp_req_b && !gb)) ? 1 : 0;
    chk("grant_a", int'(grant_a), ga);
    chk("grant_b", int'(grant_b), gb);
    chk("rob_num_a", int'(rob_num_a), m_tail);
    chk("rob_num_b", int'(rob_num_b), (m_tail + 1) % D);
    chk("stall", int'(stall), a_stall);
    chk("head_ptr", int'(head_ptr), m_head);
    chk("count", int'(count), m_count);
    chk("full", int'(full), (m_count == D) ? 1 : 0);
    chk("empty", int'(empty), (m_count == 0) ? 1 : 0);
    chk("err", int'(err), int'(m_err));
  endtask

  // Apply one cycle of inputs at the falling edge, then compare against the model.
  task automatic step(input bit ra, input bit rb, input bit ta, input bit tb_,
                      input bit fl, input bit rs);
    @(negedge clk);
    disp_req_a = ra; disp_req_b = rb; retire_a = ta; retire_b = tb_;
    flush = fl; reset = rs;
    #1;
    check_model();
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    reset = 1; disp_req_a = 0; disp_req_b = 0; retire_a = 0; retire_b = 0; flush = 0;

    // Reset state.
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    chk("rst_rob_num_a", int'(rob_num_a), 0);
    chk("rst_rob_num_b", int'(rob_num_b), 1);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_count", int'(count), 0);

    // Paired dispatch fills the buffer in eight cycles.
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, 0, 0, 0);
      chk("fill_ga", int'(grant_a), 1);
      chk("fill_gb", int'(grant_b), 1);
      chk("fill_num_a", int'(rob_num_a), 2 * i);
      chk("fill_num_b", int'(rob_num_b), 2 * i + 1);
    end
    step(1, 1, 0, 0, 0, 0);
    chk("full_flag", int'(full), 1);
    chk("full_count", int'(count), 16);
    chk("full_stall", int'(stall), 1);
    chk("full_ga", int'(grant_a), 0);

    // A retire does not free a slot for a dispatch in the same cycle.
    step(1, 0, 1, 0, 0, 0);
    chk("fullret_ga", int'(grant_a), 0);
    chk("fullret_stall", int'(stall), 1);
    step(1, 0, 0, 0, 0, 0);
    chk("fullret_count", int'(count), 15);
    chk("fullret_ga2", int'(grant_a), 1);
    chk("fullret_num", int'(rob_num_a), 0);

    // Retiring from an empty buffer sets a sticky error flag.
    do_reset();
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("empty_ret_err", int'(err), 1);
    chk("empty_ret_count", int'(count), 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("err_sticky", int'(err), 1);

    // With one free slot only slot A is granted.
    do_reset();
    chk("err_cleared", int'(err), 0);
    for (int i = 0; i < 7; i++) step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("c15_ga", int'(grant_a), 1);
    chk("c15_num_a", int'(rob_num_a), 15);
    chk("c15_gb", int'(grant_b), 0);
    chk("c15_stall", int'(stall), 1);
    step(0, 0, 0, 0, 0, 0);
    chk("c15_count", int'(count), 16);
    chk("c15_full", int'(full), 1);

    // The head pointer wraps when entries retire in pairs.
    for (int i = 0; i < 7; i++) step(0, 0, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    chk("wrap_head0", int'(head_ptr), 14);
    chk("wrap_count0", int'(count), 4);
    step(0, 0, 1, 0, 0, 0);
    chk("wrap_head1", int'(head_ptr), 0);
    chk("wrap_count1", int'(count), 2);
    step(0, 0, 0, 0, 0, 0);
    chk("wrap_head2", int'(head_ptr), 1);
    chk("wrap_count2", int'(count), 1);

    // A flush clears the buffer and blocks grants for one recovery cycle.
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    chk("flush_count7", int'(count), 7);
    chk("flush_ga", int'(grant_a), 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rec_count", int'(count), 0);
    chk("rec_head", int'(head_ptr), 0);
    chk("rec_ga", int'(grant_a), 0);
    chk("rec_stall", int'(stall), 1);
    step(1, 0, 0, 0, 0, 0);
    chk("post_rec_ga", int'(grant_a), 1);
    chk("post_rec_num", int'(rob_num_a), 0);

    // A flush during recovery starts the recovery cycle again.
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reflush_ga", int'(grant_a), 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reflush_ga2", int'(grant_a), 1);

    // Random traffic, with occasional protocol violations, flushes and resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit ra, rb, ta, tb_, fl, rs;
      ra  = ($urandom_range(0, 99) < 60);
      rb  = ra ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 3);
      ta  = (m_count > 0) ? ($urandom_range(0, 99) < 55) : ($urandom_range(0, 99) < 3);
      tb_ = ta ? ((m_count > 1) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 5))
               : ($urandom_range(0, 99) < 2);
      fl  = ($urandom_range(0, 99) < 3);
      rs  = ($urandom_range(0, 299) == 0);
      step(ra, rb, ta, tb_, fl, rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
